// File: rtl/tl_ul_mon_pkg.sv
// Shared opcodes, error codes and helper functions for the TL-UL protocol monitor.
package tl_ul_mon_pkg;

   localparam logic [2:0] A_PUT_FULL        = 3'd0;
   localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] A_GET             = 3'd4;
   localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
   localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

   // Lane masks are built this wide so a request spilling past the beat still mismatches.
   localparam int MAX_LANES = 64;

   typedef enum logic [3:0] {
      ERR_NONE          = 4'd0,
      ERR_A_OPCODE      = 4'd1,
      ERR_A_PARAM       = 4'd2,
      ERR_A_SIZE        = 4'd3,
      ERR_A_ALIGN       = 4'd4,
      ERR_A_MASK        = 4'd5,
      ERR_A_STABLE      = 4'd6,
      ERR_A_DUP_SOURCE  = 4'd7,
      ERR_D_OPCODE      = 4'd8,
      ERR_D_IDLE_SOURCE = 4'd9,
      ERR_D_SIZE        = 4'd10,
      ERR_D_STABLE      = 4'd11,
      ERR_D_PARAM       = 4'd12,
      ERR_TIMEOUT       = 4'd13
   } err_code_e;

   function automatic logic [2:0] exp_d_opcode(input logic [2:0] a_opcode);
      return (a_opcode == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
   endfunction

   function automatic logic [MAX_LANES-1:0] lane_mask(input int addr_lsbs, input int size);
      logic [MAX_LANES-1:0] lanes;
      int lo;
      int hi;
      lanes = '0;
      lo    = addr_lsbs;
      hi    = (size > 6) ? lo + MAX_LANES : lo + (1 << size);
      for (int i = 0; i < MAX_LANES; i++)
         lanes[i] = (i >= lo) && (i < hi);
      return lanes;
   endfunction

endpackage

// File: rtl/tl_ul_mon_src_table.sv
// Per-source in-flight table {inflight, opcode, size}; age counters and timeout
// vector are built only when TL_UL_MONITOR_WATCHDOG_EN is defined.
module tl_ul_mon_src_table
   import tl_ul_mon_pkg::*;
#(
   parameter int SRC_W   = 2,
   parameter int SIZE_W  = 3,
   parameter int TIMEOUT = 1023
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  set_en,
   input  logic [SRC_W-1:0]      set_src,
   input  logic [2:0]            set_opcode,
   input  logic [SIZE_W-1:0]     set_size,
   input  logic                  clr_en,
   input  logic [SRC_W-1:0]      clr_src,
   input  logic [SRC_W-1:0]      lookup_src,
   output logic                  lookup_inflight,
   output logic [2:0]            lookup_opcode,
   output logic [SIZE_W-1:0]     lookup_size,
   output logic [2**SRC_W-1:0]   inflight_vec,
   output logic [2**SRC_W-1:0]   inflight_nxt,
   output logic [2**SRC_W-1:0]   timeout_vec
);

   localparam int NSRC = 2 ** SRC_W;

   typedef struct packed {
      logic              inflight;
      logic [2:0]        opcode;
      logic [SIZE_W-1:0] size;
   } entry_t;

   entry_t          table_q [NSRC];
   logic [NSRC-1:0] set_hit;
   logic [NSRC-1:0] clr_hit;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("tl_ul_mon_src_table: TIMEOUT must be at least 1");
   end

   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         set_hit[i]      = set_en && (set_src == SRC_W'(i));
         clr_hit[i]      = clr_en && (clr_src == SRC_W'(i));
         inflight_vec[i] = table_q[i].inflight;
         // A new request on the same source wins over the retiring response.
         inflight_nxt[i] = set_hit[i] || (table_q[i].inflight && !clr_hit[i]);
      end
   end

   assign lookup_inflight = table_q[lookup_src].inflight;
   assign lookup_opcode   = table_q[lookup_src].opcode;
   assign lookup_size     = table_q[lookup_src].size;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the table is a handful of flops, so every entry is reset; a reset
         // mid-transaction must leave no stale inflight bit behind.
         for (int i = 0; i < NSRC; i++)
            table_q[i] <= '0;
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (set_hit[i])
               table_q[i] <= '{inflight: 1'b1, opcode: set_opcode, size: set_size};
            else if (clr_hit[i])
               table_q[i].inflight <= 1'b0;
         end
      end
   end

`ifdef TL_UL_MONITOR_WATCHDOG_EN
   localparam int AGE_W = $clog2(TIMEOUT + 1);

   logic [AGE_W-1:0] age_q [NSRC];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NSRC; i++)
            age_q[i] <= '0;
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (set_hit[i])
               age_q[i] <= '0;
            else if (table_q[i].inflight && age_q[i] != AGE_W'(TIMEOUT))
               age_q[i] <= age_q[i] + 1'b1;
         end
      end
   end

   // Fires on the cycle the age would reach TIMEOUT; saturation prevents a repeat.
   always_comb begin
      for (int i = 0; i < NSRC; i++)
         timeout_vec[i] = table_q[i].inflight && !set_hit[i] && !clr_hit[i] &&
                          (age_q[i] == AGE_W'(TIMEOUT - 1));
   end
`else
   assign timeout_vec = '0;
`endif

endmodule

// File: rtl/tl_ul_protocol_monitor.sv
// Passive TL-UL single-beat protocol checker for one A/D link; the per-source
// watchdog (code 13) is enabled by defining TL_UL_MONITOR_WATCHDOG_EN.
module tl_ul_protocol_monitor
   import tl_ul_mon_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int SRC_W      = 2,
   parameter int SIZE_W     = 3,
   parameter int BEAT_BYTES = 4,
   parameter int TIMEOUT    = 1023
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  a_valid,
   input  logic                  a_ready,
   input  logic [2:0]            a_opcode,
   input  logic [2:0]            a_param,
   input  logic [SIZE_W-1:0]     a_size,
   input  logic [SRC_W-1:0]      a_source,
   input  logic [ADDR_W-1:0]     a_address,
   input  logic [BEAT_BYTES-1:0] a_mask,
   input  logic                  d_valid,
   input  logic                  d_ready,
   input  logic [2:0]            d_opcode,
   input  logic [1:0]            d_param,
   input  logic [SIZE_W-1:0]     d_size,
   input  logic [SRC_W-1:0]      d_source,
   output logic                  err_valid,
   output logic [3:0]            err_code,
   output logic [15:0]           err_sticky,
   output logic [SRC_W:0]        inflight_count
);

   localparam int NSRC     = 2 ** SRC_W;
   localparam int LANE_W   = (BEAT_BYTES > 1) ? $clog2(BEAT_BYTES) : 1;
   localparam int MAX_SIZE = $clog2(BEAT_BYTES);

   typedef struct packed {
      logic [2:0]            opcode;
      logic [2:0]            param;
      logic [SIZE_W-1:0]     size;
      logic [SRC_W-1:0]      source;
      logic [ADDR_W-1:0]     address;
      logic [BEAT_BYTES-1:0] mask;
   } a_fields_t;

   typedef struct packed {
      logic [2:0]        opcode;
      logic [1:0]        param;
      logic [SIZE_W-1:0] size;
      logic [SRC_W-1:0]  source;
   } d_fields_t;

   a_fields_t            a_cur, a_hold_q;
   d_fields_t            d_cur, d_hold_q;
   logic                 a_stall_q, d_stall_q;
   logic                 a_fire, d_fire;
   logic                 a_op_legal, a_size_legal;
   logic                 zero_latency, set_en;
   logic [NSRC-1:0]      inflight_vec, inflight_nxt, timeout_vec;
   logic                 lk_inflight;
   logic [2:0]           lk_opcode;
   logic [SIZE_W-1:0]    lk_size;
   logic [ADDR_W-1:0]    align_bits;
   logic [MAX_LANES-1:0] lanes, mask_ext;
   logic [15:0]          errs;
   err_code_e            first_err;

   assign a_fire       = a_valid && a_ready;
   assign d_fire       = d_valid && d_ready;
   assign a_cur        = {a_opcode, a_param, a_size, a_source, a_address, a_mask};
   assign d_cur        = {d_opcode, d_param, d_size, d_source};
   assign a_op_legal   = a_opcode inside {A_PUT_FULL, A_PUT_PARTIAL, A_GET};
   assign a_size_legal = int'(a_size) <= MAX_SIZE;
   assign align_bits   = ~({ADDR_W{1'b1}} << a_size);
   assign lanes        = lane_mask(int'(a_address[LANE_W-1:0]), int'(a_size));
   assign mask_ext     = MAX_LANES'(a_mask);

   // A response in the same cycle as its request to an idle source never touches the table.
   assign zero_latency = a_fire && d_fire && (a_source == d_source) && !inflight_vec[d_source];
   assign set_en       = a_fire && a_op_legal && a_size_legal && !zero_latency;

   tl_ul_mon_src_table #(
      .SRC_W   (SRC_W),
      .SIZE_W  (SIZE_W),
      .TIMEOUT (TIMEOUT)
   ) u_src_table (
      .clock           (clock),
      .reset_n         (reset_n),
      .set_en          (set_en),
      .set_src         (a_source),
      .set_opcode      (a_opcode),
      .set_size        (a_size),
      .clr_en          (d_fire),
      .clr_src         (d_source),
      .lookup_src      (d_source),
      .lookup_inflight (lk_inflight),
      .lookup_opcode   (lk_opcode),
      .lookup_size     (lk_size),
      .inflight_vec    (inflight_vec),
      .inflight_nxt    (inflight_nxt),
      .timeout_vec     (timeout_vec)
   );

   always_comb begin
      // NOTE: errs is cleared first so every path assigns every bit and no latch forms.
      errs = '0;
      if (a_valid) begin
         errs[ERR_A_OPCODE] = !a_op_legal;
         errs[ERR_A_PARAM]  = a_param != 3'd0;
         errs[ERR_A_SIZE]   = !a_size_legal;
         errs[ERR_A_ALIGN]  = (a_address & align_bits) != '0;
         if (a_op_legal && a_size_legal) begin
            if (a_opcode == A_PUT_PARTIAL)
               errs[ERR_A_MASK] = (mask_ext & ~lanes) != '0;
            else
               errs[ERR_A_MASK] = mask_ext != lanes;
         end
         errs[ERR_A_DUP_SOURCE] = a_ready && inflight_vec[a_source] &&
                                  !(d_fire && d_source == a_source);
      end
      errs[ERR_A_STABLE] = a_stall_q && (!a_valid || a_cur != a_hold_q);

      if (d_fire) begin
         if (lk_inflight) begin
            errs[ERR_D_OPCODE] = d_opcode != exp_d_opcode(lk_opcode);
            errs[ERR_D_SIZE]   = d_size != lk_size;
         end else if (zero_latency) begin
            errs[ERR_D_OPCODE] = d_opcode != exp_d_opcode(a_opcode);
            errs[ERR_D_SIZE]   = d_size != a_size;
         end else begin
            errs[ERR_D_IDLE_SOURCE] = 1'b1;
         end
      end
      errs[ERR_D_STABLE] = d_stall_q && (!d_valid || d_cur != d_hold_q);
      errs[ERR_D_PARAM]  = d_valid && d_param != 2'd0;
      errs[ERR_TIMEOUT]  = |timeout_vec;
   end

   always_comb begin
      first_err = ERR_NONE;
      for (int i = 15; i > 0; i--)
         if (errs[i]) first_err = err_code_e'(4'(i));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_stall_q      <= 1'b0;
         d_stall_q      <= 1'b0;
         a_hold_q       <= '0;
         d_hold_q       <= '0;
         err_valid      <= 1'b0;
         err_code       <= ERR_NONE;
         err_sticky     <= '0;
         inflight_count <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         a_stall_q      <= a_valid && !a_ready;
         d_stall_q      <= d_valid && !d_ready;
         a_hold_q       <= a_cur;
         d_hold_q       <= d_cur;
         err_valid      <= |errs;
         err_code       <= first_err;
         err_sticky     <= err_sticky | errs;
         inflight_count <= (SRC_W + 1)'($countones(inflight_nxt));
      end
   end

endmodule
